uart_txq: RTL and testbench
===========================

# uart_txq

Buffered, runtime-configurable UART transmitter for the SoC peripheral layer. Bytes written through a valid/ready port are held in an internal FIFO and serialised LSB-first on `uart_txd`. Per frame, the block inserts a start bit, 5–8 data bits, an optional parity bit and 1 or 2 stop bits. Bit period is a runtime divisor, so one instance serves any baud rate without re-synthesis.

## Interface
- `FIFO_DEPTH`, 4: TX FIFO entries; power of two, ≥2.
- `DIV_W`, 16: width of the bit-period divisor.
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cfg_div` in `DIV_W`: clock cycles per UART bit; values 0 and 1 are treated as 2.
- `cfg_data_bits` in 2: data bits per frame; 0→5, 1→6, 2→7, 3→8.
- `cfg_stop2` in 1: 1 selects two stop bits; 0 selects one.
- `cfg_parity_en` in 1: enables the parity bit (only with the macro).
- `cfg_parity_odd` in 1: 1 selects odd parity, 0 selects even (only with the macro).
- `wr_valid` in 1: write request.
- `wr_data` in 8: byte to send; unused upper bits are ignored.
- `wr_ready` out 1: FIFO not full.
- `uart_txd` out 1: serial line, registered, idles high.
- `busy` out 1: high when a frame is in progress or the FIFO is non-empty.
- `tx_done` out 1: one-cycle pulse at the end of each frame.
- `fifo_level` out `$clog2(FIFO_DEPTH)+1`: number of occupied FIFO entries.

## Operation
- Write: a byte is accepted on an edge where `wr_valid && wr_ready`.
  - `wr_ready = (fifo_level != FIFO_DEPTH)`; it is registered-state only and does not depend on the same-cycle pop.
  - A write while full is dropped; FIFO contents are unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE→START when the FIFO is non-empty. On that edge the head entry is popped and all five `cfg_*` inputs are latched for the whole frame.
  - START→DATA after 1 bit period.
  - DATA→PARITY after N data bits, if parity is enabled; otherwise DATA→STOP.
  - PARITY→STOP after 1 bit period.
  - STOP ends after 1 or 2 bit periods. It then goes to START (popping the next entry) if the FIFO is non-empty, otherwise to IDLE. There is no idle gap between back-to-back frames.
- Bit counter: counts 0..`cfg_div`-1. On terminal count the block advances to the next bit and the counter wraps to 0.
- Parity bit = XOR of the N data bits, XOR `cfg_parity_odd`.
- Changes to `cfg_*` mid-frame have no effect until the next pop.
- `tx_done` is asserted in the last cycle of the final stop bit.
- Simultaneous write and pop: both happen; `fifo_level` is unchanged. A write to an empty FIFO in IDLE is popped on the following edge.
- Pointers wrap modulo `FIFO_DEPTH`. Full/empty are distinguished by `fifo_level`.

## Timing
- Reset values:
  - `uart_txd` = 1, `wr_ready` = 1, `busy` = 0, `tx_done` = 0, `fifo_level` = 0.
  - FSM = IDLE, FIFO empty.
- Reset asserted mid-frame: the line returns high immediately (asynchronous) and queued data is discarded.
- Write at edge k into an idle, empty block:
  - the pop occurs at edge k+1;
  - `uart_txd` = 0 from edge k+1;
  - every line bit lasts exactly D = max(`cfg_div`, 2) cycles.
- Frame length = D × (1 + N + P + S) cycles, where N is the data-bit count, P is 1 if parity is enabled, and S is the stop-bit count.
- `tx_done` is high in cycle D×(1+N+P+S) − 1, counted from the start-bit edge.

## Configuration
- `UART_TXQ_PARITY_EN` defined:
  - PARITY state and parity logic are compiled in;
  - `cfg_parity_en` and `cfg_parity_odd` are honoured.
- Undefined:
  - PARITY state is never entered and parity logic is omitted;
  - both parity ports remain present but are ignored;
  - frames are always N data bits with no parity.

## Test plan
- 8N1 with `cfg_div`=4; write 0xA5:
  - `uart_txd` sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 4 cycles;
  - `tx_done` pulses once, 39 cycles after the start bit begins.
- Back-to-back writes 0x55 then 0x0F:
  - the second start bit immediately follows the first stop bit with no gap;
  - `busy` stays high throughout;
  - exactly 2 `tx_done` pulses.
- FIFO full, depth 4, `cfg_div`=2: write 6 bytes on consecutive cycles:
  - 5 bytes are accepted (1 popped, 4 queued) and the 6th is dropped;
  - `wr_ready` is low while `fifo_level`=4;
  - the line carries exactly the 5 accepted bytes, in order.
- With the macro, 7O2 (`cfg_data_bits`=2, `cfg_stop2`=1, parity odd), byte 0x07:
  - data bits 1,1,1,0,0,0,0;
  - parity bit 0;
  - two stop bits;
  - frame length 11×D.
- 5N1, byte 0xFF:
  - 5 data bits are all 1 and the upper bits are not sent;
  - frame length 7×D.
- Assert `rst_n` low in the middle of the DATA state with 2 bytes queued:
  - `uart_txd`=1 immediately, `fifo_level`=0, and `tx_done` never pulses;
  - after release, a new write 0x3C is sent correctly.

Source files
------------

// File: rtl/uart_txq.sv
// Buffered UART transmitter: valid/ready byte FIFO feeding a runtime-configurable serialiser.
// Optional parity support is compiled in when UART_TXQ_PARITY_EN is defined.
`timescale 1ns/1ps
module uart_txq #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [1:0]                    cfg_data_bits,
  input  logic                          cfg_stop2,
  input  logic                          cfg_parity_en,
  input  logic                          cfg_parity_odd,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic                          uart_txd,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state, state_nx;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              push, pop, bit_end, last_data, last_stop;
  logic [DIV_W-1:0]  bit_cnt, div_q;
  logic [2:0]        bit_idx;
  logic [1:0]        nbits_q;
  logic              stop2_q, par_en_q, par_bit_q;
  logic [7:0]        shreg;
  logic              par_calc, par_en_in;

  assign wr_ready  = (fifo_level != LW'(FIFO_DEPTH));
  assign push      = wr_valid && wr_ready;
  assign busy      = (state != IDLE) || (fifo_level != '0);
  assign bit_end   = (bit_cnt == div_q - DIV_W'(1));
  assign last_data = (bit_idx == (3'd4 + {1'b0, nbits_q}));
  assign last_stop = !stop2_q || bit_idx[0];
  assign tx_done   = (state == STOP) && bit_end && last_stop;

`ifdef UART_TXQ_PARITY_EN
  // Parity is taken over the head entry masked to the configured width at pop time.
  logic [7:0] par_mask;
  assign par_mask  = 8'hFF >> (2'd3 - cfg_data_bits);
  assign par_calc  = (^(mem[rd_ptr] & par_mask)) ^ cfg_parity_odd;
  assign par_en_in = cfg_parity_en;
`else
  logic unused_parity;
  assign unused_parity = cfg_parity_en ^ cfg_parity_odd;
  assign par_calc  = 1'b0;
  assign par_en_in = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fifo_level <= fifo_level + LW'(1);
      else if (pop && !push) fifo_level <= fifo_level - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // A pop happens on frame start from IDLE or straight out of the last stop bit.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE:   if (fifo_level != '0) begin
                pop      = 1'b1;
                state_nx = START;
              end
      START:  if (bit_end) state_nx = DATA;
      DATA:   if (bit_end && last_data) state_nx = par_en_q ? PARITY : STOP;
      PARITY: if (bit_end) state_nx = STOP;
      STOP:   if (bit_end && last_stop) begin
                if (fifo_level != '0) begin
                  pop      = 1'b1;
                  state_nx = START;
                end else begin
                  state_nx = IDLE;
                end
              end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_txd  <= 1'b1;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      div_q     <= DIV_W'(2);
      nbits_q   <= 2'd3;
      stop2_q   <= 1'b0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (pop) begin
      shreg     <= mem[rd_ptr];
      div_q     <= (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
      nbits_q   <= cfg_data_bits;
      stop2_q   <= cfg_stop2;
      par_en_q  <= par_en_in;
      par_bit_q <= par_calc;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      uart_txd  <= 1'b0;
    end else if (state != IDLE) begin
      bit_cnt <= bit_end ? '0 : bit_cnt + DIV_W'(1);
      if (bit_end) begin
        case (state)
          START: uart_txd <= shreg[0];
          DATA: begin
            if (last_data) begin
              bit_idx  <= '0;
              uart_txd <= par_en_q ? par_bit_q : 1'b1;
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              shreg    <= shreg >> 1;
              uart_txd <= shreg[1];
            end
          end
          PARITY: uart_txd <= 1'b1;
          STOP: begin
            bit_idx  <= bit_idx + 3'd1;
            uart_txd <= 1'b1;
          end
          default: uart_txd <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_txq.sv
// Scoreboard bench for uart_txq: stimulus queues hand-computed frames, a line monitor checks them.
`timescale 1ns/1ps
module tb_uart_txq;

  typedef struct {
    logic [11:0] bits;
    int          len;
    int          d;
    bit          contig;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cfg_div;
  logic [1:0]  cfg_data_bits;
  logic        cfg_stop2, cfg_parity_en, cfg_parity_odd;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ready, uart_txd, busy, tx_done;
  logic [2:0]  fifo_level;

  frame_t exp_q[$];
  int     errors = 0;
  int     checks = 0;
  bit     mon_en = 1'b1;
  bit     in_frame = 1'b0;

  uart_txq dut (
    .clk(clk), .rst_n(rst_n), .cfg_div(cfg_div), .cfg_data_bits(cfg_data_bits),
    .cfg_stop2(cfg_stop2), .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .uart_txd(uart_txd),
    .busy(busy), .tx_done(tx_done), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic setCfg(input int div, input int nb, input bit stop2, input bit pen, input bit podd);
    cfg_div        = 16'(div);
    cfg_data_bits  = 2'(nb);
    cfg_stop2      = stop2;
    cfg_parity_en  = pen;
    cfg_parity_odd = podd;
  endtask

  // Drives one write cycle; the expected frame is queued only if the byte should be accepted.
  task automatic applyStimulus(input logic [7:0] data, input logic [11:0] bits, input int len,
                               input int d, input bit contig, input bit accept);
    frame_t f;
    f.bits = bits; f.len = len; f.d = d; f.contig = contig;
    if (accept) exp_q.push_back(f);
    wr_valid = 1'b1;
    wr_data  = data;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic waitIdle(input int max_cycles, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (!busy && !in_frame && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput(name, 32'(ok), 32'd1);
    @(negedge clk);
  endtask

  // Line monitor: a low line while idle starts a frame, every bit is checked for value and width.
  initial begin : monitor
    frame_t      it;
    logic [11:0] seen;
    int          unstable, done_hits, done_last;
    bit          have_start;
    have_start = 1'b0;
    forever begin
      if (!have_start) begin
        @(negedge clk);
        if (!(mon_en && rst_n === 1'b1 && uart_txd === 1'b0)) continue;
      end
      have_start = 1'b0;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_frame", 32'd1, 32'd0);
        for (int i = 0; i < 40 && uart_txd === 1'b0; i++) @(negedge clk);
        continue;
      end
      it = exp_q.pop_front();
      in_frame = 1'b1;
      seen = '0; unstable = 0; done_hits = 0; done_last = 0;
      for (int b = 0; b < it.len; b++) begin
        for (int c = 0; c < it.d; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (c == 0) seen[b] = uart_txd;
          else if (uart_txd !== seen[b]) unstable++;
          if (tx_done === 1'b1) begin
            done_hits++;
            if (b == it.len - 1 && c == it.d - 1) done_last = 1;
          end
        end
      end
      checkOutput("frame_bits", 32'(seen), 32'(it.bits));
      checkOutput("bit_width", 32'(unstable), 32'd0);
      checkOutput("tx_done_pos", 32'(done_hits * 2 + done_last), 32'd3);
      in_frame = 1'b0;
      if (exp_q.size() != 0 && exp_q[0].contig) begin
        @(negedge clk);
        checkOutput("no_gap", 32'(uart_txd), 32'd0);
        have_start = (uart_txd === 1'b0);
      end
    end
  end

  initial begin : stimulus
    logic [7:0]  fifo_bytes [6];
    logic [11:0] fifo_frames [6];
    int          exp_lvl [6];
    int          busy_low, dn;
    fifo_bytes  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    fifo_frames = '{12'h222, 12'h244, 12'h266, 12'h288, 12'h2AA, 12'h000};
    exp_lvl     = '{1, 1, 2, 3, 4, 4};

    rst_n = 1'b0;
    wr_valid = 1'b0;
    wr_data = 8'h00;
    setCfg(4, 3, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("reset_txd", 32'(uart_txd), 32'd1);
    checkOutput("reset_wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_tx_done", 32'(tx_done), 32'd0);
    checkOutput("reset_level", 32'(fifo_level), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] 8N1 div4 0xA5 with mid-frame cfg change");
    applyStimulus(8'hA5, 12'h34A, 10, 4, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    setCfg(7, 0, 1'b1, 1'b1, 1'b1);
    waitIdle(200, "idle_a5");

    $display("[TB] back-to-back 0x55, 0x0F");
    setCfg(4, 3, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h55, 12'h2AA, 10, 4, 1'b0, 1'b1);
    applyStimulus(8'h0F, 12'h21E, 10, 4, 1'b1, 1'b1);
    busy_low = 0;
    dn = 0;
    for (int i = 0; i < 150 && dn < 2; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_low++;
      if (tx_done === 1'b1) dn++;
    end
    checkOutput("b2b_busy_low_cycles", 32'(busy_low), 32'd0);
    checkOutput("b2b_done_count", 32'(dn), 32'd2);
    waitIdle(50, "idle_b2b");

    $display("[TB] FIFO full, div2, 6 writes");
    setCfg(2, 3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(fifo_bytes[i], fifo_frames[i], 10, 2, i > 0, i < 5);
      checkOutput("fifo_level", 32'(fifo_level), 32'(exp_lvl[i]));
      checkOutput("fifo_wr_ready", 32'(wr_ready), 32'(exp_lvl[i] != 4));
    end
    waitIdle(300, "idle_fifo");

    $display("[TB] 7 bits, 2 stop, odd parity requested, 0x07");
    setCfg(3, 2, 1'b1, 1'b1, 1'b1);
`ifdef UART_TXQ_PARITY_EN
    applyStimulus(8'h07, 12'h60E, 11, 3, 1'b0, 1'b1);
`else
    applyStimulus(8'h07, 12'h30E, 10, 3, 1'b0, 1'b1);
`endif
    waitIdle(100, "idle_7o2");

    $display("[TB] 5N1 0xFF, div1 treated as 2");
    setCfg(1, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hFF, 12'h07E, 7, 2, 1'b0, 1'b1);
    waitIdle(60, "idle_5n1");

    $display("[TB] reset mid-frame");
    mon_en = 1'b0;
    setCfg(4, 3, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hAA, 12'h000, 10, 4, 1'b0, 1'b0);
    applyStimulus(8'hBB, 12'h000, 10, 4, 1'b0, 1'b0);
    applyStimulus(8'hCC, 12'h000, 10, 4, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("pre_reset_txd", 32'(uart_txd), 32'd0);
    checkOutput("pre_reset_level", 32'(fifo_level), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_txd", 32'(uart_txd), 32'd1);
    checkOutput("async_reset_level", 32'(fifo_level), 32'd0);
    checkOutput("async_reset_busy", 32'(busy), 32'd0);
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (tx_done === 1'b1) dn++;
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (tx_done === 1'b1) dn++;
    end
    checkOutput("reset_no_tx_done", 32'(dn), 32'd0);
    checkOutput("post_reset_busy", 32'(busy), 32'd0);
    mon_en = 1'b1;
    setCfg(0, 3, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h3C, 12'h278, 10, 2, 1'b0, 1'b1);
    waitIdle(60, "idle_3c");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
